// File: rtl/ex_mdu_pkg.sv
// ex_mdu_pkg: operation codes and default latencies shared by the multiply/divide unit and its users.
package ex_mdu_pkg;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;
endpackage

// File: rtl/ex_mdu_if.sv
// ex_mdu_if: EX-stage request lines into the MDU and the busy/HI/LO lines back out.
interface ex_mdu_if;
  import ex_mdu_pkg::*;
  logic        start;
  mdu_op_e     mdu_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  modport master (output start, mdu_op, src_a, src_b, input busy, hi_out, lo_out);
  modport slave  (input start, mdu_op, src_a, src_b, output busy, hi_out, lo_out);
endinterface

// File: rtl/ex_mdu.sv
// ex_mdu: multi-cycle multiply/divide unit holding architectural HI/LO.
// The result is computed at issue and held in pend_* until the latency counter expires.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic   clk,
  input logic   reset,
  ex_mdu_if.slave bus
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  logic [CW-1:0] cnt;
  logic [31:0] a, b, ua, ub, uq, ur, res_hi, res_lo, pend_hi, pend_lo;
  logic [63:0] prod;
  logic go, is_mul, is_div, sgn, pend_we;
  always_comb begin
    a      = bus.src_a;
    b      = bus.src_b;
    go     = bus.start && !bus.busy;
    is_mul = bus.mdu_op == MDU_MULT || bus.mdu_op == MDU_MULTU;
    is_div = bus.mdu_op == MDU_DIV || bus.mdu_op == MDU_DIVU;
    sgn    = bus.mdu_op == MDU_MULT || bus.mdu_op == MDU_DIV;
    prod   = sgn ? {{32{a[31]}}, a} * {{32{b[31]}}, b} : {32'd0, a} * {32'd0, b};
    // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of trapping.
    ua     = (sgn && a[31]) ? -a : a;
    ub     = (b == 32'd0) ? 32'd1 : (sgn && b[31]) ? -b : b;
    uq     = ua / ub;
    ur     = ua % ub;
    res_lo = is_mul ? prod[31:0] : (sgn && (a[31] ^ b[31])) ? -uq : uq;
    res_hi = is_mul ? prod[63:32] : (sgn && a[31]) ? -ur : ur;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.busy   <= 1'b0;
      bus.hi_out <= '0;
      bus.lo_out <= '0;
      cnt        <= '0;
      pend_hi    <= '0;
      pend_lo    <= '0;
      pend_we    <= 1'b0;
    end else if (go && (is_mul || is_div)) begin
      pend_hi  <= res_hi;
      pend_lo  <= res_lo;
      pend_we  <= is_mul || b != 32'd0;
      cnt      <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      bus.busy <= 1'b1;
    end else if (go && bus.mdu_op == MDU_MTHI) begin
      bus.hi_out <= a;
    end else if (go && bus.mdu_op == MDU_MTLO) begin
      bus.lo_out <= a;
    end else if (bus.busy) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        bus.busy <= 1'b0;
        if (pend_we) begin
          bus.hi_out <= pend_hi;
          bus.lo_out <= pend_lo;
        end
      end
    end
  end
endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed vectors against a cycle model of HI/LO/busy built from plain 64-bit arithmetic.
module tb_ex_mdu;
  import ex_mdu_pkg::*;
  localparam int MC = 5;
  localparam int DC = 10;
  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   chk_en = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   ignored = 0;
  int   m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit   p_we = 1'b0;
  ex_mdu_if bus();
  ex_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: results from signed/unsigned 64-bit arithmetic, latency as a countdown.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left = 0; m_hi = '0; m_lo = '0; p_we = 1'b0;
    end else if (m_left > 0) begin
      if (bus.start) ignored++;
      m_left--;
      if (m_left == 0 && p_we) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (bus.start) begin
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(bus.src_a));
      sb = longint'($signed(bus.src_b));
      p_we = 1'b1;
      case (bus.mdu_op)
        MDU_MULT:  begin p = sa * sb; {p_hi, p_lo} = p; m_left = MC; end
        MDU_MULTU: begin p = 64'(bus.src_a) * 64'(bus.src_b); {p_hi, p_lo} = p; m_left = MC; end
        MDU_DIV: begin
          m_left = DC;
          p_we = bus.src_b != 0;
          if (p_we) begin q = sa / sb; r = sa % sb; p_lo = q[31:0]; p_hi = r[31:0]; end
        end
        MDU_DIVU: begin
          m_left = DC;
          p_we = bus.src_b != 0;
          if (p_we) begin p_lo = bus.src_a / bus.src_b; p_hi = bus.src_a % bus.src_b; end
        end
        MDU_MTHI: m_hi = bus.src_a;
        MDU_MTLO: m_lo = bus.src_a;
        default: ;
      endcase
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("busy", 32'(bus.busy), 32'(m_left > 0));
    chk("hi", bus.hi_out, m_hi);
    chk("lo", bus.lo_out, m_lo);
  end

  task automatic issue(input mdu_op_e o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #3;
    bus.start = 1'b1; bus.mdu_op = o; bus.src_a = a; bus.src_b = b;
    @(posedge clk); #3;
    bus.start = 1'b0; bus.mdu_op = MDU_NONE;
  endtask

  task automatic wait_idle(input string name, input int exp_n);
    int n = 0;
    while (n < 60) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
    end
    chk(name, 32'(n), 32'(exp_n));
  endtask

  task automatic op_chk(input string name, input mdu_op_e o, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] eh, input logic [31:0] el);
    issue(o, a, b);
    wait_idle({name, "_len"}, n);
    chk({name, "_hi"}, bus.hi_out, eh);
    chk({name, "_lo"}, bus.lo_out, el);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0; bus.mdu_op = MDU_NONE; bus.src_a = '0; bus.src_b = '0;
    #1 reset = 1'b0;
    #1 chk_en = 1'b1;
    bus.start = 1'b1; bus.mdu_op = MDU_MULT; bus.src_a = 32'd5; bus.src_b = 32'd5;
    repeat (3) begin
      @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_hi", bus.hi_out, 32'd0);
      chk("rst_lo", bus.lo_out, 32'd0);
    end
    @(posedge clk); #3;
    bus.start = 1'b0; bus.mdu_op = MDU_NONE; reset = 1'b1;
    @(negedge clk);
    chk("rel_busy", 32'(bus.busy), 32'd0);
    chk("rel_hi", bus.hi_out, 32'd0);

    op_chk("mult", MDU_MULT, 32'hFFFFFFFE, 32'd3, MC, 32'hFFFFFFFF, 32'hFFFFFFFA);
    op_chk("multu", MDU_MULTU, 32'hFFFFFFFE, 32'd3, MC, 32'h00000002, 32'hFFFFFFFA);
    op_chk("mult_big", MDU_MULT, 32'h80000000, 32'h80000000, MC, 32'h40000000, 32'h00000000);
    op_chk("div", MDU_DIV, 32'hFFFFFFF9, 32'd2, DC, 32'hFFFFFFFF, 32'hFFFFFFFD);
    op_chk("divu", MDU_DIVU, 32'd7, 32'd2, DC, 32'd1, 32'd3);
    op_chk("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, DC, 32'd0, 32'h80000000);
    op_chk("div_pn", MDU_DIV, 32'd7, 32'hFFFFFFFE, DC, 32'd1, 32'hFFFFFFFD);

    issue(MDU_MTHI, 32'h11, 32'd0);
    issue(MDU_MTLO, 32'h22, 32'd0);
    op_chk("div0", MDU_DIV, 32'd9, 32'd0, DC, 32'h11, 32'h22);
    op_chk("divu0", MDU_DIVU, 32'd9, 32'd0, DC, 32'h11, 32'h22);

    issue(MDU_MTHI, 32'h12345678, 32'd0);
    chk("mthi_busy", 32'(bus.busy), 32'd0);
    chk("mthi_hi", bus.hi_out, 32'h12345678);
    chk("mthi_lo", bus.lo_out, 32'h22);
    issue(MDU_MTLO, 32'h9ABCDEF0, 32'd0);
    chk("mtlo_busy", 32'(bus.busy), 32'd0);
    chk("mtlo_hi", bus.hi_out, 32'h12345678);
    chk("mtlo_lo", bus.lo_out, 32'h9ABCDEF0);

    issue(MDU_MULT, 32'd6, 32'd7);
    chk("stale_hi", bus.hi_out, 32'h12345678);
    @(posedge clk); #3;
    bus.start = 1'b1; bus.mdu_op = MDU_DIV; bus.src_a = 32'd100; bus.src_b = 32'd3;
    @(posedge clk); #3;
    bus.start = 1'b0; bus.mdu_op = MDU_NONE;
    wait_idle("ovl_len", MC - 2);
    chk("ovl_hi", bus.hi_out, 32'd0);
    chk("ovl_lo", bus.lo_out, 32'd42);
    chk("ovl_ignored", 32'(ignored), 32'd1);
    repeat (DC + 2) @(negedge clk);
    chk("ovl_quiet", 32'(bus.busy), 32'd0);

    issue(MDU_DIV, 32'hFFFFFFF9, 32'd2);
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_hi", bus.hi_out, 32'd0);
    chk("arst_lo", bus.lo_out, 32'd0);
    @(posedge clk); #3;
    reset = 1'b1;
    op_chk("post_rst", MDU_MULT, 32'h00010000, 32'h00010000, MC, 32'd1, 32'd0);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
